ttt_board_ctrl: RTL and testbench

- Turn-sequencing board register for the tic-tac-toe datapath.
- Accepts player and computer moves and validates them.
- Stores the 9-cell board (2 bits per cell) and drives it to the downstream winner-detection stage.
- Consumes that stage's win/who result to decide whether the game continues, is won, or is drawn.

---
 rtl/ttt_board_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_ttt_board_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_board_ctrl.sv
// ttt_board_ctrl
// Turn-sequencing board register for the tic-tac-toe datapath. Accepts and
// validates player and computer moves, holds the 9-cell board (2 bits per
// cell, row-major), presents it to the winner-detection stage, and uses that
// stage's win/who answer to decide whether the game continues, is won or is
// drawn.
//
// Ports:
//   clock        - system clock, everything on the rising edge
//   reset_n      - synchronous active-low reset
//   new_game     - pulse: clear the board and restart at the player's turn
//   play         - pulse: player move request to cell player_pos
//   player_pos   - player target cell index (0..8 legal)
//   pc_play      - pulse: computer move request to cell pc_pos
//   pc_pos       - computer target cell index (0..8 legal)
//   win, who     - from winner detection, combinational on the board
//   board        - cell k at bits [2k+1:2k]; 00 empty, 01 player, 10 computer
//   turn         - 0 player to move, 1 computer to move
//   move_count   - moves committed this game (0..9)
//   illegal_move - one-cycle pulse after a rejected move
//   game_over    - high once the game is decided
//   winner       - winning code latched from who, 00 when no win
//   draw         - high when the board filled with no win
module ttt_board_ctrl #(
  parameter int         N_CELLS       = 9,
  parameter logic [1:0] PLAYER_CODE   = 2'b01,
  parameter logic [1:0] COMPUTER_CODE = 2'b10
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   new_game,
  input  logic                   play,
  input  logic [3:0]             player_pos,
  input  logic                   pc_play,
  input  logic [3:0]             pc_pos,
  input  logic                   win,
  input  logic [1:0]             who,
  output logic [2*N_CELLS-1:0]   board,
  output logic                   turn,
  output logic [3:0]             move_count,
  output logic                   illegal_move,
  output logic                   game_over,
  output logic [1:0]             winner,
  output logic                   draw
);

  localparam int         BOARD_W   = 2 * N_CELLS;
  localparam logic [3:0] FULL_MOVES = 4'(N_CELLS);

  typedef enum logic [1:0] {
    PLAYER_TURN   = 2'd0,
    COMPUTER_TURN = 2'd1,
    CHECK         = 2'd2,
    GAME_OVER     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [BOARD_W-1:0]   board_q, board_d;
  logic                 turn_q, turn_d;
  logic [3:0]           move_count_q, move_count_d;
  logic                 illegal_q, illegal_d;
  logic                 game_over_q, game_over_d;
  logic [1:0]           winner_q, winner_d;
  logic                 draw_q, draw_d;

  // Signals describing the move request that is live in the current state.
  logic                 req_valid;
  logic [3:0]           req_pos;
  logic [1:0]           req_code;
  logic                 req_legal;
  logic [1:0]           req_cell;

  // Read the current contents of a cell; an index past the board reads as
  // non-empty so it is naturally rejected.
  function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] b,
                                         input logic [3:0]         idx);
    logic [1:0] c;
    c = 2'b11;
    for (int k = 0; k < N_CELLS; k++) begin
      if (idx == 4'(k)) c = b[2*k +: 2];
    end
    return c;
  endfunction

  // Return the board with one cell overwritten by the given code.
  function automatic logic [BOARD_W-1:0] set_cell(input logic [BOARD_W-1:0] b,
                                                  input logic [3:0]         idx,
                                                  input logic [1:0]         code);
    logic [BOARD_W-1:0] r;
    r = b;
    for (int k = 0; k < N_CELLS; k++) begin
      if (idx == 4'(k)) r[2*k +: 2] = code;
    end
    return r;
  endfunction

  // Select which request matters in this state: the player's in PLAYER_TURN,
  // the computer's in COMPUTER_TURN, none elsewhere (requests are dropped).
  always_comb begin
    req_valid = 1'b0;
    req_pos   = player_pos;
    req_code  = PLAYER_CODE;
    case (state_q)
      PLAYER_TURN: begin
        req_valid = play;
        req_pos   = player_pos;
        req_code  = PLAYER_CODE;
      end
      COMPUTER_TURN: begin
        req_valid = pc_play;
        req_pos   = pc_pos;
        req_code  = COMPUTER_CODE;
      end
      default: begin
        req_valid = 1'b0;
      end
    endcase
    req_cell  = cell_at(board_q, req_pos);
    req_legal = (req_pos < FULL_MOVES) && (req_cell == 2'b00);
  end

  // Next-state and output logic. CHECK lasts exactly one cycle and relies on
  // win/who already reflecting the board committed on the previous edge.
  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    turn_d       = turn_q;
    move_count_d = move_count_q;
    illegal_d    = 1'b0;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    draw_d       = draw_q;

    case (state_q)
      PLAYER_TURN, COMPUTER_TURN: begin
        if (req_valid) begin
          if (req_legal) begin
            board_d = set_cell(board_q, req_pos, req_code);
            if (move_count_q < FULL_MOVES) move_count_d = move_count_q + 4'd1;
            state_d = CHECK;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      CHECK: begin
        if (win) begin
          winner_d    = who;
          game_over_d = 1'b1;
          state_d     = GAME_OVER;
        end else if (move_count_q == FULL_MOVES) begin
          draw_d      = 1'b1;
          game_over_d = 1'b1;
          state_d     = GAME_OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = turn_d ? COMPUTER_TURN : PLAYER_TURN;
        end
      end
      GAME_OVER: begin
        state_d = GAME_OVER;
      end
      default: begin
        state_d = PLAYER_TURN;
      end
    endcase

    // A new game overrides any move request arriving in the same cycle.
    if (new_game) begin
      state_d      = PLAYER_TURN;
      board_d      = '0;
      turn_d       = 1'b0;
      move_count_d = 4'd0;
      illegal_d    = 1'b0;
      game_over_d  = 1'b0;
      winner_d     = 2'b00;
      draw_d       = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= PLAYER_TURN;
      board_q      <= '0;
      turn_q       <= 1'b0;
      move_count_q <= 4'd0;
      illegal_q    <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 2'b00;
      draw_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      turn_q       <= turn_d;
      move_count_q <= move_count_d;
      illegal_q    <= illegal_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      draw_q       <= draw_d;
    end
  end

  assign board        = board_q;
  assign turn         = turn_q;
  assign move_count   = move_count_q;
  assign illegal_move = illegal_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;
  assign draw         = draw_q;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// tb_ttt_board_ctrl
// Directed bench for ttt_board_ctrl. A small winner-detection model looks at
// the DUT board and drives win/who back, as the real downstream stage would.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_ttt_board_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        new_game;
  logic        play;
  logic [3:0]  player_pos;
  logic        pc_play;
  logic [3:0]  pc_pos;
  logic        win;
  logic [1:0]  who;
  logic [17:0] board;
  logic        turn;
  logic [3:0]  move_count;
  logic        illegal_move;
  logic        game_over;
  logic [1:0]  winner;
  logic        draw;

  int vectorCount   = 0;
  int miscompareCnt = 0;

  ttt_board_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .new_game     (new_game),
    .play         (play),
    .player_pos   (player_pos),
    .pc_play      (pc_play),
    .pc_pos       (pc_pos),
    .win          (win),
    .who          (who),
    .board        (board),
    .turn         (turn),
    .move_count   (move_count),
    .illegal_move (illegal_move),
    .game_over    (game_over),
    .winner       (winner),
    .draw         (draw)
  );

  always #5 clock = ~clock;

  // Owner of a line of three cells, 00 when the line is not uniform.
  function automatic logic [1:0] lineOwner(input logic [17:0] b,
                                           input int x, input int y, input int z);
    logic [1:0] ca, cb, cc;
    ca = b[2*x +: 2];
    cb = b[2*y +: 2];
    cc = b[2*z +: 2];
    return (ca != 2'b00 && ca == cb && ca == cc) ? ca : 2'b00;
  endfunction

  // Winner-detection model: first winning line found reports its owner.
  always_comb begin
    logic [1:0] owner;
    owner = 2'b00;
    if (owner == 2'b00) owner = lineOwner(board, 0, 1, 2);
    if (owner == 2'b00) owner = lineOwner(board, 3, 4, 5);
    if (owner == 2'b00) owner = lineOwner(board, 6, 7, 8);
    if (owner == 2'b00) owner = lineOwner(board, 0, 3, 6);
    if (owner == 2'b00) owner = lineOwner(board, 1, 4, 7);
    if (owner == 2'b00) owner = lineOwner(board, 2, 5, 8);
    if (owner == 2'b00) owner = lineOwner(board, 0, 4, 8);
    if (owner == 2'b00) owner = lineOwner(board, 2, 4, 6);
    win = (owner != 2'b00);
    who = owner;
  end

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [17:0] actual,
                             input logic [17:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompareCnt++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  // Drive one move request for a single cycle; returns on the falling edge
  // after the board has been updated (or the move rejected).
  task automatic applyStimulus(input bit isPc, input logic [3:0] pos);
    if (isPc) begin
      pc_play = 1'b1;
      pc_pos  = pos;
    end else begin
      play       = 1'b1;
      player_pos = pos;
    end
    @(negedge clock);
    play    = 1'b0;
    pc_play = 1'b0;
  endtask

  // A full legal move: request cycle plus the CHECK cycle.
  task automatic doMove(input bit isPc, input logic [3:0] pos);
    applyStimulus(isPc, pos);
    @(negedge clock);
  endtask

  task automatic startNewGame();
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".board"},      18'(board),        18'h0);
    checkOutput({tag, ".turn"},       18'(turn),         18'h0);
    checkOutput({tag, ".move_count"}, 18'(move_count),   18'h0);
    checkOutput({tag, ".illegal"},    18'(illegal_move), 18'h0);
    checkOutput({tag, ".game_over"},  18'(game_over),    18'h0);
    checkOutput({tag, ".winner"},     18'(winner),       18'h0);
    checkOutput({tag, ".draw"},       18'(draw),         18'h0);
  endtask

  initial begin
    reset_n    = 1'b0;
    new_game   = 1'b0;
    play       = 1'b0;
    player_pos = 4'd0;
    pc_play    = 1'b0;
    pc_pos     = 4'd0;
    repeat (2) @(negedge clock);
    checkResetValues("reset");
    reset_n = 1'b1;

    // First player move into the centre.
    applyStimulus(1'b0, 4'd4);
    checkOutput("p4.board",      board,             18'h00100);
    checkOutput("p4.move_count", 18'(move_count),   18'd1);
    checkOutput("p4.turn_early", 18'(turn),         18'd0);
    @(negedge clock);
    checkOutput("p4.turn",       18'(turn),         18'd1);

    // Computer tries an occupied cell, then an off-board index.
    applyStimulus(1'b1, 4'd4);
    checkOutput("c4.illegal",    18'(illegal_move), 18'd1);
    checkOutput("c4.board",      board,             18'h00100);
    @(negedge clock);
    checkOutput("c4.pulse_end",  18'(illegal_move), 18'd0);
    applyStimulus(1'b1, 4'd9);
    checkOutput("c9.illegal",    18'(illegal_move), 18'd1);
    checkOutput("c9.board",      board,             18'h00100);
    checkOutput("c9.move_count", 18'(move_count),   18'd1);
    @(negedge clock);
    // Player requests are ignored during the computer's turn.
    applyStimulus(1'b0, 4'd5);
    checkOutput("p5_ignored",    board,             18'h00100);
    checkOutput("p5_no_illegal", 18'(illegal_move), 18'd0);
    // Still the computer's turn: a legal computer move lands.
    doMove(1'b1, 4'd0);
    checkOutput("c0.board",      board,             18'h00102);
    checkOutput("c0.turn",       18'(turn),         18'd0);
    checkOutput("c0.move_count", 18'(move_count),   18'd2);

    // Player wins along the top row.
    startNewGame();
    checkOutput("ng.board",      board,             18'h0);
    doMove(1'b0, 4'd0);
    doMove(1'b1, 4'd3);
    doMove(1'b0, 4'd1);
    doMove(1'b1, 4'd4);
    doMove(1'b0, 4'd2);
    checkOutput("win.game_over", 18'(game_over),    18'd1);
    checkOutput("win.winner",    18'(winner),       18'd1);
    checkOutput("win.draw",      18'(draw),         18'd0);
    checkOutput("win.moves",     18'(move_count),   18'd5);
    checkOutput("win.board",     board,             18'h00295);
    applyStimulus(1'b0, 4'd8);
    checkOutput("over.board",    board,             18'h00295);
    checkOutput("over.illegal",  18'(illegal_move), 18'd0);
    checkOutput("over.moves",    18'(move_count),   18'd5);

    // Nine moves, no line completed: draw.
    startNewGame();
    doMove(1'b0, 4'd0);
    doMove(1'b1, 4'd1);
    doMove(1'b0, 4'd2);
    doMove(1'b1, 4'd4);
    doMove(1'b0, 4'd3);
    doMove(1'b1, 4'd5);
    doMove(1'b0, 4'd7);
    doMove(1'b1, 4'd6);
    doMove(1'b0, 4'd8);
    checkOutput("draw.game_over", 18'(game_over),   18'd1);
    checkOutput("draw.draw",      18'(draw),        18'd1);
    checkOutput("draw.winner",    18'(winner),      18'd0);
    checkOutput("draw.moves",     18'(move_count),  18'd9);
    checkOutput("draw.board",     board,            18'h16A59);

    // Reset while the game is over.
    reset_n = 1'b0;
    @(negedge clock);
    checkResetValues("rst_over");
    reset_n = 1'b1;

    // new_game wins over a simultaneous play mid-game.
    doMove(1'b0, 4'd0);
    doMove(1'b1, 4'd1);
    play       = 1'b1;
    player_pos = 4'd5;
    new_game   = 1'b1;
    @(negedge clock);
    play     = 1'b0;
    new_game = 1'b0;
    checkOutput("ngplay.board",   board,             18'h0);
    checkOutput("ngplay.moves",   18'(move_count),   18'd0);
    checkOutput("ngplay.turn",    18'(turn),         18'd0);
    checkOutput("ngplay.illegal", 18'(illegal_move), 18'd0);
    @(negedge clock);
    checkOutput("ngplay.illegal2", 18'(illegal_move), 18'd0);
    doMove(1'b0, 4'd4);
    checkOutput("ngplay.p4",      board,             18'h00100);
    checkOutput("ngplay.p4_turn", 18'(turn),         18'd1);

    // Reset while the controller sits in CHECK.
    startNewGame();
    applyStimulus(1'b0, 4'd0);
    reset_n = 1'b0;
    @(negedge clock);
    checkResetValues("rst_check");
    reset_n = 1'b1;
    applyStimulus(1'b0, 4'd0);
    checkOutput("after_rst.board", board,            18'h00001);
    checkOutput("after_rst.moves", 18'(move_count),  18'd1);
    @(negedge clock);
    checkOutput("after_rst.turn",  18'(turn),        18'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCnt);
    $finish;
  end

  // Safety net in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
